// File: rtl/irq_pkg.sv
// Shared types and default sizing for the interrupt request controller.
package irq_pkg;

   localparam int unsigned NumSrcDef = 4;
   localparam int unsigned IdWDef    = 3;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StService
   } irq_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: two-flop synchroniser plus a previous-value flop for rising-edge detect.
module irq_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic irq_i,
   output logic edge_o
);

   logic sync1_q, sync2_q, prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= irq_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   assign edge_o = sync2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: edge capture into pending bits, masking, fixed priority and
// a request/acknowledge/end-of-interrupt handshake with the CPU.
module irq_ctrl
   import irq_pkg::*;
#(
   parameter int unsigned        NUM_SRC  = NumSrcDef,
   parameter int unsigned        ID_W     = IdWDef,
   parameter logic [NUM_SRC-1:0] MASK_RST = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] EX_irq,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   input  logic               INTA_irq,
   input  logic               eoi,
   output logic               INT_irq,
   output logic [ID_W-1:0]    irq_id,
   output logic               in_service,
   output logic [NUM_SRC-1:0] pending,
   output logic [NUM_SRC-1:0] mask
);

   irq_state_e         state_q;
   logic               int_q, insvc_q;
   logic [ID_W-1:0]    id_q;
   logic [NUM_SRC-1:0] pending_q, pending_d, mask_q;
   logic [NUM_SRC-1:0] edge_evt, active, pend_clr;
   logic [ID_W-1:0]    win_id;
   logic               win_vld;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
      irq_sync_edge u_sync (
         .clk    (clk),
         .rst    (rst),
         .irq_i  (EX_irq[g]),
         .edge_o (edge_evt[g])
      );
   end

   assign active = pending_q & ~mask_q;

   // Scan from the top so the lowest active index is the last one written.
   always_comb begin
      win_id  = '0;
      win_vld = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (active[i]) begin
            win_vld = 1'b1;
            win_id  = ID_W'(i);
         end
      end
   end

   // A new edge on the source being acknowledged survives the clear.
   always_comb begin
      pend_clr = '0;
      if (state_q == StReq && INTA_irq) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (id_q == ID_W'(i)) pend_clr[i] = 1'b1;
         end
      end
      pending_d = (pending_q & ~pend_clr) | edge_evt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q <= '0;
         mask_q    <= MASK_RST;
      end else begin
         pending_q <= pending_d;
         if (mask_we) mask_q <= mask_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         int_q   <= 1'b0;
         id_q    <= '0;
         insvc_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (win_vld) begin
                  state_q <= StReq;
                  int_q   <= 1'b1;
                  id_q    <= win_id;
               end
            end
            StReq: begin
               if (INTA_irq) begin
                  state_q <= StService;
                  int_q   <= 1'b0;
                  insvc_q <= 1'b1;
               end
            end
            StService: begin
               if (eoi) begin
                  state_q <= StIdle;
                  insvc_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign INT_irq    = int_q;
   assign irq_id     = id_q;
   assign in_service = insvc_q;
   assign pending    = pending_q;
   assign mask       = mask_q;

endmodule
